ifetch_queue: RTL and testbench

//  Instruction fetch stage that sits between ram_unit port 1 and the decoder.

---
 rtl/ifetch_queue.sv | 82 ++++++++
 tb/tb_ifetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with a credit-limited FIFO and redirect flush
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       memReq,
    output logic [31:0]                memAdr,
    input  logic                       memGnt,
    input  logic                       memRspV,
    input  logic [31:0]                memRspD,
    output logic                       iValid,
    output logic [31:0]                iReg,
    output logic [31:0]                iPc,
    input  logic                       iReady,
    input  logic                       jmpFlag,
    input  logic [31:0]                jmpTarget,
    input  logic                       halt,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   fetchPc, rspPc;
    logic [31:0]   words [DEPTH];
    logic [31:0]   pcs [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count, outs, stale, outsNext;
    logic          issue, keep, pop;
    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign memReq    = !reset && !halt && !jmpFlag &&
                       (({1'b0, count} + {1'b0, outs}) < (CW+1)'(DEPTH));
    assign memAdr    = fetchPc;
    assign issue     = memReq && memGnt;
    assign keep      = memRspV && stale == '0 && !jmpFlag;
    assign iValid    = count != '0;
    assign pop       = iValid && iReady;
    assign iReg      = words[rdPtr];
    assign iPc       = pcs[rdPtr];
    assign occupancy = count;
    assign outsNext  = outs + CW'(issue) - CW'(memRspV);
    // Responses return in order, so the pc of the next kept word is just a running counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc <= RESET_PC;
            rspPc   <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            outs    <= '0;
            stale   <= '0;
        end else begin
            outs <= outsNext;
            if (jmpFlag) begin
                fetchPc <= jmpTarget;
                rspPc   <= jmpTarget;
                rdPtr   <= wrPtr;
                count   <= '0;
                stale   <= outsNext;
            end else begin
                if (issue) fetchPc <= fetchPc + PC_STEP;
                if (memRspV && stale != '0) stale <= stale - CW'(1);
                if (keep) begin
                    wrPtr <= wrPtr + AW'(1);
                    rspPc <= rspPc + PC_STEP;
                end
                if (pop) rdPtr <= rdPtr + AW'(1);
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (keep) begin
            words[wrPtr] <= memRspD;
            pcs[wrPtr]   <= rspPc;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) assert (!(memRspV && count == CW'(DEPTH)));
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios with a variable-latency memory model and a pop scoreboard
module tb_ifetch_queue;
    localparam logic [31:0] KEY = 32'h5A5A_0000;
    logic        clk = 0;
    logic        reset = 1;
    logic        memReq, memGnt, memRspV, iValid, iReady, jmpFlag, halt;
    logic [31:0] memAdr, memRspD, iReg, iPc, jmpTarget;
    logic [2:0]  occupancy;
    int          total = 0, bad = 0, popCount = 0, lat = 1, cur = 0, mcyc = 0;
    logic [31:0] expq[$];
    logic [31:0] padr[$];
    int          pdue[$];

    ifetch_queue dut (
        .clk(clk), .reset(reset), .memReq(memReq), .memAdr(memAdr), .memGnt(memGnt),
        .memRspV(memRspV), .memRspD(memRspD), .iValid(iValid), .iReg(iReg), .iPc(iPc),
        .iReady(iReady), .jmpFlag(jmpFlag), .jmpTarget(jmpTarget), .halt(halt),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory: grants every request, returns data = addr ^ KEY after lat cycles, in order.
    initial begin
        memRspV = 0;
        memRspD = '0;
        memGnt  = 1;
        forever begin
            @(negedge clk);
            mcyc++;
            if (padr.size() > 0 && pdue[0] <= mcyc) begin
                memRspV = 1;
                memRspD = padr[0] ^ KEY;
                void'(padr.pop_front());
                void'(pdue.pop_front());
            end else memRspV = 0;
            #4;
            if (reset) begin
                padr.delete();
                pdue.delete();
            end else if (memReq && memGnt) begin
                padr.push_back(memAdr);
                pdue.push_back(mcyc + lat);
            end
        end
    end

    // Monitor: every accepted head is checked against the next expected pc.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && iValid && iReady) begin
                popCount++;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_pop: got pc %h want none", iPc);
                end else begin
                    e = expq.pop_front();
                    chk("pop_pc", iPc, e);
                    chk("pop_instr", iReg, e ^ KEY);
                end
            end
        end
    end

    task automatic go(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    task automatic do_reset(input logic rdy, input int l);
        @(negedge clk);
        reset = 1; halt = 0; jmpFlag = 0; jmpTarget = '0; iReady = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_memReq", 32'(memReq), 0);
        chk("rst_iValid", 32'(iValid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        expq.delete();
        popCount = 0;
        lat = l;
        @(negedge clk);
        reset = 0;
        iReady = rdy;
        cur = 0;
    endtask

    task automatic finish_test(input int n);
        iReady = 0;
        go(cur + 2);
        chk("pop_count", 32'(popCount), 32'(n));
        chk("exp_left", 32'(expq.size()), 0);
    endtask

    initial begin
        halt = 0; jmpFlag = 0; jmpTarget = '0; iReady = 0;
        // streaming with 1-cycle memory, then halt and resume
        do_reset(1, 1);
        for (int i = 0; i < 14; i++) expq.push_back(32'(4 * i));
        #2;
        chk("s_req0", 32'(memReq), 1);
        chk("s_adr0", memAdr, 0);
        chk("s_val0", 32'(iValid), 0);
        go(1); #2;
        chk("s_adr1", memAdr, 4);
        chk("s_val1", 32'(iValid), 0);
        go(2); #2;
        chk("s_val2", 32'(iValid), 1);
        chk("s_pc2", iPc, 0);
        go(10); halt = 1; #2;
        chk("h_req", 32'(memReq), 0);
        go(12); #2;
        chk("h_val", 32'(iValid), 0);
        chk("h_occ", 32'(occupancy), 0);
        go(14); halt = 0; #2;
        chk("h_resreq", 32'(memReq), 1);
        chk("h_resadr", memAdr, 32'h28);
        go(16); #2;
        chk("h_pc", iPc, 32'h28);
        go(20);
        finish_test(14);
        // backpressure fills the queue, then releases in order
        do_reset(0, 1);
        for (int i = 0; i < 8; i++) expq.push_back(32'(4 * i));
        go(6); #2;
        chk("bp_req", 32'(memReq), 0);
        chk("bp_occ", 32'(occupancy), 4);
        chk("bp_val", 32'(iValid), 1);
        chk("bp_pc", iPc, 0);
        go(8); iReady = 1; #2;
        chk("bp_req8", 32'(memReq), 0);
        go(9); #2;
        chk("bp_req9", 32'(memReq), 1);
        chk("bp_adr9", memAdr, 16);
        go(16);
        finish_test(8);
        // 3-cycle memory, jump with two requests in flight
        do_reset(1, 3);
        for (int i = 0; i < 4; i++) expq.push_back(32'h100 + 32'(4 * i));
        go(2); jmpFlag = 1; jmpTarget = 32'h100; #2;
        chk("j_req", 32'(memReq), 0);
        go(3); jmpFlag = 0; #2;
        chk("j_req3", 32'(memReq), 1);
        chk("j_adr3", memAdr, 32'h100);
        for (int c = 4; c < 7; c++) begin
            go(c); #2;
            chk("j_occ", 32'(occupancy), 0);
            chk("j_val", 32'(iValid), 0);
        end
        go(7); #2;
        chk("j_val7", 32'(iValid), 1);
        chk("j_pc7", iPc, 32'h100);
        go(12); iReady = 0; #2;
        chk("j_occ12", 32'(occupancy), 1);
        finish_test(4);
        // jump coincident with a response and a pop
        do_reset(1, 1);
        foreach (expq[i]) ;
        expq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204};
        go(5); jmpFlag = 1; jmpTarget = 32'h200; #2;
        chk("c_rsp", 32'(memRspV), 1);
        chk("c_pc", iPc, 32'hC);
        go(6); jmpFlag = 0; #2;
        chk("c_val", 32'(iValid), 0);
        chk("c_occ", 32'(occupancy), 0);
        chk("c_req", 32'(memReq), 1);
        chk("c_adr", memAdr, 32'h200);
        go(8); #2;
        chk("c_pc8", iPc, 32'h200);
        go(10);
        finish_test(6);
        // address wrap past 0xFFFFFFFC
        do_reset(1, 1);
        expq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        jmpFlag = 1; jmpTarget = 32'hFFFF_FFF8; #2;
        chk("w_req0", 32'(memReq), 0);
        go(1); jmpFlag = 0; #2;
        chk("w_adr1", memAdr, 32'hFFFF_FFF8);
        go(2); #2;
        chk("w_adr2", memAdr, 32'hFFFF_FFFC);
        go(3); #2;
        chk("w_adr3", memAdr, 32'h0);
        go(5); #2;
        chk("w_pc5", iPc, 32'h0);
        go(7);
        finish_test(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
